adc_frame_sequencer: RTL
========================

// Module: adc_frame_sequencer
// PURPOSE
//  Main-clock controller for the SPI ADC receiver. It crosses the receiver's async frame-done flag into the clock domain and
//  sequences a settle/capture/verify read of both 16-bit channel words. It presents coherent sample pairs to the synth core
//  with a valid/ack handshake and tracks overruns, corrupt captures and link timeout.
// PARAMETERS
//  DATA_WIDTH      16        channel word width
//  SYNC_STAGES     2         flops in rx_flag synchroniser (>=2)
//  SETTLE_CYCLES   2         cycles after synced edge before capture (>=1)
//  TIMEOUT_CYCLES  2000000   cycles without a good frame before stale asserts
//  SMOOTH_SHIFT    3         IIR coefficient 2^-N (used only with ADC_SMOOTH_EN)
// PORTS
//  clock         in   1    main clock
//  reset_n       in   1    async reset, active-low
//  enable        in   1    sequencer run enable
//  rx_flag       in   1    frame-received flag from SPI receiver, async to clock
//  rx_data0      in   16   channel 0 word from receiver, valid only while rx_flag high
//  rx_data1      in   16   channel 1 word from receiver, valid only while rx_flag high
//  sample0       out  16   registered channel 0 sample
//  sample1       out  16   registered channel 1 sample
//  sample_valid  out  1    new pair available; held until sample_ack
//  sample_ack    in   1    consumer accept; clears sample_valid
//  stale         out  1    no good frame for TIMEOUT_CYCLES
//  overrun_cnt   out  8    saturating count of unacked overwrites
//  error_cnt     out  8    saturating count of aborted or mismatched captures
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; sync chain 0; timeout counter 0.
//  rx_flag passes through SYNC_STAGES flops. rise = synced & ~synced_d. fall = ~synced & synced_d.
//  FSM states: IDLE -> SETTLE -> CAPTURE -> VERIFY -> IDLE.
//   IDLE: on rise, go to SETTLE and load settle_cnt = SETTLE_CYCLES-1.
//   SETTLE: count down to 0, then go to CAPTURE. If the synced flag goes low here, error_cnt++ and go to IDLE.
//   CAPTURE: latch rx_data0/1 into shadow regs, go to VERIFY.
//   VERIFY: compare shadow regs with live rx_data0/1.
//    Equal and synced flag still high: commit the pair to sample0/1, set sample_valid, clear timeout, clear stale, go to IDLE.
//    Any mismatch or flag low: error_cnt++, outputs unchanged, go to IDLE.
//  Latency: the commit edge is SYNC_STAGES+SETTLE_CYCLES+3 clock edges after the first edge that samples rx_flag high
//   (7 at defaults). sample_valid is high from that commit edge onward.
//  Handshake: sample_ack while valid clears valid on the next edge.
//   Commit while valid is high and no ack that cycle: overwrite samples, valid stays 1, overrun_cnt++.
//   Commit and ack in the same cycle: overwrite samples, valid stays 1, no overrun.
//  Counters: overrun_cnt and error_cnt saturate at 255 and clear only on reset.
//  Timeout: cycle counter increments every cycle while enable is high and saturates at TIMEOUT_CYCLES.
//   stale is 1 whenever counter == TIMEOUT_CYCLES. A commit resets counter to 0 and stale to 0 on the same edge.
//  enable low: FSM forced to IDLE next edge; valid cleared; timeout counter held at 0; stale cleared; samples held.
//   The sync chain keeps running, so an rx_flag already high when enable rises does not produce a rise.
//  reset_n low mid-sequence: immediate return to reset values; any partial capture is discarded.
// CONFIGURATION
//  ADC_SMOOTH_EN defined: on commit, sampleN <= sampleN + ((newN - sampleN) >>> SMOOTH_SHIFT).
//   Subtraction uses signed DATA_WIDTH+1 bits, with the result truncated to DATA_WIDTH.
//   The first commit after reset or enable rise loads the value directly.
//  ADC_SMOOTH_EN undefined: on commit, sampleN <= newN. SMOOTH_SHIFT is unused.
// STRUCTURE
//  Package adc_seq_pkg holds the state typedef (IDLE/SETTLE/CAPTURE/VERIFY), the DATA_WIDTH default and the CNT_MAX=8'hFF constant.
//  Sub-module adc_flag_sync: SYNC_STAGES-deep synchroniser plus rise/fall pulses, asynchronous reset_n.
//  The top level holds the FSM, shadow regs, counters and optional filter.
// TESTING
//  1. rx_flag rises with data0=16'h1234 and data1=16'hABCD, held for 20 cycles:
//     sample0/1 update and sample_valid rises exactly 7 edges later; ack clears valid the next edge.
//  2. rx_flag held for only 3 cycles: error_cnt==1, sample_valid stays 0, samples unchanged.
//  3. rx_data0 changes 16'h0001->16'h0002 during VERIFY: error_cnt increments and no commit occurs.
//  4. Three frames with no ack: samples equal the third frame, overrun_cnt==2, sample_valid==1.
//  5. TIMEOUT_CYCLES=100 with no frames: stale rises at cycle 100; next good frame clears it on the commit edge.
//  6. With ADC_SMOOTH_EN and SMOOTH_SHIFT=3, frames of 0 then 16'h0800: first commit gives 0, second gives 16'h0100.
//     Without the macro, the second commit gives 16'h0800.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC frame sequencer and its flag synchroniser.
package adc_seq_pkg;

  localparam int         DATA_WIDTH_DEF = 16;
  localparam logic [7:0] CNT_MAX        = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    VERIFY
  } seq_state_t;

  // Event counters stick at CNT_MAX instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == CNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/adc_flag_sync.sv
// Multi-flop synchroniser for the receiver's frame flag, with single-cycle rise/fall pulses.
module adc_flag_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_flag,
  output logic synced,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   synced_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain    <= '0;
      synced_d <= 1'b0;
    end else begin
      chain    <= {chain[SYNC_STAGES-2:0], async_flag};
      synced_d <= chain[SYNC_STAGES-1];
    end
  end

  assign synced = chain[SYNC_STAGES-1];
  assign rise   = synced & ~synced_d;
  assign fall   = ~synced & synced_d;

endmodule

// File: rtl/adc_frame_sequencer.sv
// Settle/capture/verify sequencer delivering coherent ADC sample pairs over a valid/ack handshake.
// Define ADC_SMOOTH_EN to pass committed samples through a first-order IIR filter.
module adc_frame_sequencer
  import adc_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int SMOOTH_SHIFT   = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  rx_flag,
  input  logic [DATA_WIDTH-1:0] rx_data0,
  input  logic [DATA_WIDTH-1:0] rx_data1,
  output logic [DATA_WIDTH-1:0] sample0,
  output logic [DATA_WIDTH-1:0] sample1,
  output logic                  sample_valid,
  input  logic                  sample_ack,
  output logic                  stale,
  output logic [7:0]            overrun_cnt,
  output logic [7:0]            error_cnt
);

  localparam int             SCW         = $clog2(SETTLE_CYCLES + 1);
  localparam int             TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]  TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  seq_state_t            state, state_nxt;
  logic [SCW-1:0]        settle_cnt, settle_cnt_nxt;
  logic [DATA_WIDTH-1:0] shadow0, shadow1;
  logic [DATA_WIDTH-1:0] commit0, commit1;
  logic [TW-1:0]         timeout_cnt;
  logic                  flag_synced, flag_rise, flag_fall;
  logic                  capture, commit, abort;

  adc_flag_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_flag_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .async_flag (rx_flag),
    .synced     (flag_synced),
    .rise       (flag_rise),
    .fall       (flag_fall)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    capture        = 1'b0;
    commit         = 1'b0;
    abort          = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (flag_rise) begin
            state_nxt      = SETTLE;
            settle_cnt_nxt = SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (flag_fall) begin
            abort     = 1'b1;
            state_nxt = IDLE;
          end else if (settle_cnt == '0) begin
            state_nxt = CAPTURE;
          end else begin
            settle_cnt_nxt = settle_cnt - 1'b1;
          end
        end
        CAPTURE: begin
          capture   = 1'b1;
          state_nxt = VERIFY;
        end
        VERIFY: begin
          // A word that moved between capture and verify means the receiver was mid-update.
          if (flag_synced && (shadow0 == rx_data0) && (shadow1 == rx_data1)) begin
            commit = 1'b1;
          end else begin
            abort = 1'b1;
          end
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef ADC_SMOOTH_EN
  logic have_sample;

  function automatic logic [DATA_WIDTH-1:0] smooth(input logic [DATA_WIDTH-1:0] old_v,
                                                   input logic [DATA_WIDTH-1:0] new_v);
    logic signed [DATA_WIDTH:0] diff;
    diff = $signed({1'b0, new_v}) - $signed({1'b0, old_v});
    diff = diff >>> SMOOTH_SHIFT;
    return old_v + diff[DATA_WIDTH-1:0];
  endfunction

  // The filter only starts once a real sample exists; the first one loads directly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      have_sample <= 1'b0;
    end else if (!enable) begin
      have_sample <= 1'b0;
    end else if (commit) begin
      have_sample <= 1'b1;
    end
  end

  assign commit0 = have_sample ? smooth(sample0, shadow0) : shadow0;
  assign commit1 = have_sample ? smooth(sample1, shadow1) : shadow1;
`else
  assign commit0 = shadow0;
  assign commit1 = shadow1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow0      <= '0;
      shadow1      <= '0;
      sample0      <= '0;
      sample1      <= '0;
      sample_valid <= 1'b0;
      overrun_cnt  <= '0;
      error_cnt    <= '0;
      timeout_cnt  <= '0;
    end else begin
      if (capture) begin
        shadow0 <= rx_data0;
        shadow1 <= rx_data1;
      end
      if (!enable) begin
        sample_valid <= 1'b0;
        timeout_cnt  <= '0;
      end else begin
        if (commit) begin
          sample0      <= commit0;
          sample1      <= commit1;
          sample_valid <= 1'b1;
          timeout_cnt  <= '0;
          if (sample_valid && !sample_ack) begin
            overrun_cnt <= sat_inc(overrun_cnt);
          end
        end else begin
          if (sample_ack) begin
            sample_valid <= 1'b0;
          end
          if (timeout_cnt != TIMEOUT_MAX) begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        if (abort) begin
          error_cnt <= sat_inc(error_cnt);
        end
      end
    end
  end

  assign stale = (timeout_cnt == TIMEOUT_MAX);

endmodule
